weight_csc_stream_reader: RTL

- Downstream consumer of the PE weight address spad and weight data spad.
- Walks the CSC-compressed weight matrix column by column:
  - reads each column's end pointer from the address spad;
  - streams that column's nonzero (weight, row) entries from the data spad to the PE MAC datapath over a valid/ready interface.
- Empty columns are skipped. An address value of 0 terminates the matrix early.

---
 rtl/weight_csc_stream_reader.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/weight_csc_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : weight_csc_stream_reader
// Purpose  : Walks a CSC-compressed weight matrix one column at a time. For
//            each column it fetches the end pointer from the address spad,
//            then streams the column's (weight, row) entries from the data
//            spad to the MAC datapath over a valid/ready handshake.
//            Empty columns are skipped. An address value of 0 ends the walk
//            early.
// Ports    : clock, reset            - clock, synchronous active-high reset
//            start, num_cols         - walk request (num_cols 0 means 32)
//            addr_idx/_en, addr_data - address spad read port (1-cycle latency)
//            data_idx/_en, data_rd   - data spad read port (1-cycle latency)
//            w_valid/w_ready, w_data, w_row, w_col, w_last - weight stream
//            col_done, done          - single-cycle completion pulses
//            busy, err               - walk in progress / sticky pointer error
// Revision : 1.0 - initial release
// ============================================================================
module weight_csc_stream_reader #(
  parameter int ADDR_W     = 7,
  parameter int COL_IDX_W  = 5,
  parameter int WDATA_W    = 8,
  parameter int ROW_W      = 4,
  parameter int EMPTY_CODE = 127
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [COL_IDX_W-1:0]       num_cols,
  output logic [COL_IDX_W-1:0]       addr_idx,
  output logic                       addr_idx_en,
  input  logic [ADDR_W-1:0]          addr_data,
  output logic [ADDR_W-1:0]          data_idx,
  output logic                       data_idx_en,
  input  logic [WDATA_W+ROW_W-1:0]   data_rd,
  output logic                       w_valid,
  input  logic                       w_ready,
  output logic [WDATA_W-1:0]         w_data,
  output logic [ROW_W-1:0]           w_row,
  output logic [COL_IDX_W-1:0]       w_col,
  output logic                       w_last,
  output logic                       col_done,
  output logic                       done,
  output logic                       busy,
  output logic                       err
);

  // One extra bit so the column budget can hold the full column count.
  localparam int CNT_W = COL_IDX_W + 1;

  localparam logic [ADDR_W-1:0]    c_EMPTY    = ADDR_W'(EMPTY_CODE);
  localparam logic [ADDR_W-1:0]    c_PTR_ONE  = ADDR_W'(1);
  localparam logic [COL_IDX_W-1:0] c_COL_ONE  = COL_IDX_W'(1);
  localparam logic [CNT_W-1:0]     c_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]     c_MAX_COLS = {1'b1, {COL_IDX_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ADDR_REQ = 2'd1,
    S_ADDR_CHK = 2'd2,
    S_STREAM   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_W-1:0]     r_ptr;
  logic [ADDR_W-1:0]     r_end;
  logic [COL_IDX_W-1:0]  r_col;
  logic [CNT_W-1:0]      r_cols_left;
  logic                  r_err;

  logic [ADDR_W-1:0]     w_ptr_nxt;
  logic [ADDR_W-1:0]     w_end_nxt;
  logic [COL_IDX_W-1:0]  w_col_nxt;
  logic [CNT_W-1:0]      w_cols_left_nxt;
  logic                  w_err_nxt;
  logic                  w_err_set;
  logic                  w_advance;
  logic [ADDR_W-1:0]     w_ptr_inc;
  logic                  w_is_last;

  // ptr never exceeds 126, so the increment cannot wrap.
  assign w_ptr_inc = r_ptr + c_PTR_ONE;
  assign w_is_last = (w_ptr_inc == r_end);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_end       <= '0;
      r_col       <= '0;
      r_cols_left <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_ptr       <= w_ptr_nxt;
      r_end       <= w_end_nxt;
      r_col       <= w_col_nxt;
      r_cols_left <= w_cols_left_nxt;
      r_err       <= w_err_nxt;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_ptr_nxt       = r_ptr;
    w_end_nxt       = r_end;
    w_col_nxt       = r_col;
    w_cols_left_nxt = r_cols_left;
    w_err_nxt       = r_err;
    w_err_set       = 1'b0;
    w_advance       = 1'b0;
    addr_idx        = '0;
    addr_idx_en     = 1'b0;
    data_idx        = '0;
    data_idx_en     = 1'b0;
    w_valid         = 1'b0;
    w_last          = 1'b0;
    col_done        = 1'b0;
    done            = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state    = S_ADDR_REQ;
          w_ptr_nxt       = '0;
          w_col_nxt       = '0;
          w_cols_left_nxt = (num_cols == '0) ? c_MAX_COLS : {1'b0, num_cols};
          w_err_nxt       = 1'b0;
        end
      end

      S_ADDR_REQ: begin
        addr_idx     = r_col;
        addr_idx_en  = 1'b1;
        w_next_state = S_ADDR_CHK;
      end

      S_ADDR_CHK: begin
        if (addr_data == '0) begin
          // Zero end pointer terminates the matrix without finishing a column.
          done         = 1'b1;
          w_next_state = S_IDLE;
        end else if ((addr_data == c_EMPTY) || (addr_data == r_ptr)) begin
          col_done  = 1'b1;
          w_advance = 1'b1;
        end else if (addr_data < r_ptr) begin
          w_err_set = 1'b1;
          w_err_nxt = 1'b1;
          col_done  = 1'b1;
          w_advance = 1'b1;
        end else begin
          // Prime the data spad so the first entry is present on entry to STREAM.
          data_idx     = r_ptr;
          data_idx_en  = 1'b1;
          w_end_nxt    = addr_data;
          w_next_state = S_STREAM;
        end
      end

      S_STREAM: begin
        w_valid = 1'b1;
        w_last  = w_is_last;
        if (w_ready) begin
          if (w_is_last) begin
            w_ptr_nxt = r_end;
            col_done  = 1'b1;
            w_advance = 1'b1;
          end else begin
            // Fetch the following entry in the same cycle for 1 entry/cycle.
            w_ptr_nxt   = w_ptr_inc;
            data_idx    = w_ptr_inc;
            data_idx_en = 1'b1;
          end
        end
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase

    // Column-advance decision shared by skip, error and end-of-stream paths.
    if (w_advance) begin
      if (r_cols_left == c_CNT_ONE) begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end else begin
        w_col_nxt       = r_col + c_COL_ONE;
        w_cols_left_nxt = r_cols_left - c_CNT_ONE;
        w_next_state    = S_ADDR_REQ;
      end
    end
  end

  assign w_data = (r_state == S_STREAM) ? data_rd[WDATA_W+ROW_W-1:ROW_W] : '0;
  assign w_row  = (r_state == S_STREAM) ? data_rd[ROW_W-1:0] : '0;
  assign w_col  = r_col;
  assign busy   = (r_state != S_IDLE);
  // Error is reported in the cycle it is detected and held until the next start.
  assign err    = r_err | w_err_set;

endmodule
`default_nettype wire
